// File: rtl/serial_pkg.sv
// Shared definitions for the serial_rx receiver: register offsets, FSM encoding and DATA word layout.
package serial_pkg;

  // Word offsets decoded from mem_addr[3:2]
  localparam logic [1:0] RegCtrl = 2'd0;
  localparam logic [1:0] RegData = 2'd1;
  localparam logic [1:0] RegStat = 2'd2;
  localparam logic [1:0] RegRsvd = 2'd3;

  localparam int unsigned SERIAL_MIN_DIV = 4;

  // DATA word bit positions
  localparam int unsigned DataValidBit = 31;
  localparam int unsigned DataPeBit    = 9;
  localparam int unsigned DataFeBit    = 8;

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

endpackage

// File: rtl/serial_rx_fifo.sv
// Synchronous FIFO for received entries; push and pop may coincide in any state, including full.
module serial_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FullCnt);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  // A pop frees the slot the same cycle, so a push on a full FIFO still lands
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Memory-mapped 8N1 serial receiver with entry FIFO.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit after data bit 7.
module serial_rx #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_error,
  input  logic        pin
);
  import serial_pkg::*;

  logic sync1, line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= pin;
      line  <= sync1;
    end
  end

  rx_state_e   state_q, state_d;
  logic [15:0] div_q, d_q, d_d, cnt_q, cnt_d, div_eff;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        pe_q, pe_d;
  logic        push, expire;
  logic [9:0]  push_data;

  assign div_eff = (div_q < 16'(SERIAL_MIN_DIV)) ? 16'(SERIAL_MIN_DIV) : div_q;
  assign expire  = (cnt_q == 16'd1);

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    pe_d      = pe_q;
    push      = 1'b0;
    push_data = {pe_q, ~line, shreg_q};
    if (state_q inside {StStart, StData, StParity, StStop}) cnt_d = cnt_q - 16'd1;
    case (state_q)
      StWaitIdle: if (line) state_d = StIdle;
      StIdle: begin
        if (!line) begin
          state_d = StStart;
          d_d     = div_eff;
          cnt_d   = div_eff >> 1;
          bit_d   = 3'd0;
          pe_d    = 1'b0;
        end
      end
      StStart: begin
        if (expire) begin
          // A high line at mid-start is a glitch, not a frame
          if (line) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = d_q;
          end
        end
      end
      StData: begin
        if (expire) begin
          shreg_d = {line, shreg_q[7:1]};
          cnt_d   = d_q;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      StParity: begin
        if (expire) begin
          pe_d    = line ^ (^shreg_q);
          cnt_d   = d_q;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (expire) begin
          push    = 1'b1;
          state_d = line ? StIdle : StWaitIdle;
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StWaitIdle;
      d_q     <= 16'(SERIAL_MIN_DIV);
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      pe_q    <= pe_d;
    end
  end

  logic                   pop, full, empty;
  logic [9:0]             fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;

  serial_rx_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(10)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(push_data),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (full),
    .empty(empty),
    .count(fifo_count)
  );

  logic        accept, is_wr, err, ctrl_wr, stat_wr, ovf_q, fe_sticky_q;
  logic [1:0]  reg_sel;
  logic [31:0] rdata_d;
  logic        unused_bits;

  assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16]};
  assign accept  = mem_valid && !mem_ready;
  assign is_wr   = |mem_wstrb;
  assign reg_sel = mem_addr[3:2];
  assign err     = (reg_sel == RegRsvd) ||
                   (is_wr && ((mem_wstrb != 4'hf) || (reg_sel == RegData)));
  assign ctrl_wr = accept && is_wr && !err && (reg_sel == RegCtrl);
  assign stat_wr = accept && is_wr && !err && (reg_sel == RegStat);
  // Reads see the head before any same-cycle push
  assign pop     = accept && !is_wr && (reg_sel == RegData) && !empty;

  always_comb begin
    rdata_d = '0;
    if (accept && !is_wr && !err) begin
      case (reg_sel)
        RegCtrl: rdata_d = {16'b0, div_q};
        RegData: begin
          if (!empty) begin
            rdata_d[DataValidBit] = 1'b1;
            rdata_d[DataPeBit:0]  = fifo_rdata;
          end
        end
        RegStat: rdata_d = {16'b0, 8'(fifo_count), 6'b0, fe_sticky_q, ovf_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready   <= 1'b0;
      mem_error   <= 1'b0;
      mem_rdata   <= '0;
      div_q       <= 16'hffff;
      ovf_q       <= 1'b0;
      fe_sticky_q <= 1'b0;
    end else begin
      mem_ready <= accept;
      mem_error <= accept && err;
      mem_rdata <= rdata_d;
      if (ctrl_wr) div_q <= mem_wdata[15:0];
      if (push && full && !pop)          ovf_q <= 1'b1;
      else if (stat_wr && mem_wdata[0])  ovf_q <= 1'b0;
      if (push && (push_data[DataPeBit] || push_data[DataFeBit])) fe_sticky_q <= 1'b1;
      else if (stat_wr && mem_wdata[1])                           fe_sticky_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Randomized bench for serial_rx: frames drive the pin, a queue model predicts every bus response.
module tb_serial_rx;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] A_CTRL = 32'h0, A_DATA = 32'h4, A_STAT = 32'h8, A_RSVD = 32'hc;

  logic        clk = 1'b0, rst = 1'b1, pin = 1'b1, mem_valid = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, mem_error;

  always #5 clk = ~clk;

  serial_rx #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_error(mem_error),
    .pin      (pin)
  );

  int total = 0, bad = 0;

  // Behavioural model state
  logic [9:0]  mq[$];
  logic [15:0] m_div = 16'hffff;
  logic        m_ovf = 1'b0, m_fes = 1'b0;

  // Expected response of the outstanding bus access
  logic        pending = 1'b0, prev_ready = 1'b0, exp_err = 1'b0, exp_rd = 1'b0;
  logic [31:0] exp_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (mem_ready && prev_ready) begin
        total++; bad++;
        $display("FAIL ready_pulse: got 2-cycle ready want 1-cycle");
      end
      if (mem_ready && !pending) begin
        total++; bad++;
        $display("FAIL spurious_ready: got ready want no ready");
      end else if (mem_ready) begin
        total++;
        if (mem_error !== exp_err) begin
          bad++;
          $display("FAIL bus_error @%h: got %b want %b", mem_addr, mem_error, exp_err);
        end
        if (exp_rd && !exp_err) begin
          total++;
          if (mem_rdata !== exp_rdata) begin
            bad++;
            $display("FAIL bus_rdata @%h: got %h want %h", mem_addr, mem_rdata, exp_rdata);
          end
        end
        pending = 1'b0;
      end
      prev_ready = mem_ready;
    end
  end

  function automatic logic [31:0] model_access(input logic [31:0] a, input logic [3:0] s,
                                               input logic [31:0] w, output logic e);
    logic [1:0] r;
    r = a[3:2];
    e = (r == 2'd3) || ((s != 4'h0) && ((s != 4'hf) || (r == 2'd1)));
    model_access = '0;
    if (!e) begin
      if (s != 4'h0) begin
        if (r == 2'd0) m_div = w[15:0];
        if (r == 2'd2) begin
          if (w[0]) m_ovf = 1'b0;
          if (w[1]) m_fes = 1'b0;
        end
      end else begin
        case (r)
          2'd0: model_access = {16'b0, m_div};
          2'd1: if (mq.size() > 0) model_access = {1'b1, 21'b0, mq.pop_front()};
          2'd2: model_access = {16'b0, 8'(mq.size()), 6'b0, m_fes, m_ovf};
          default: model_access = '0;
        endcase
      end
    end
  endfunction

  task automatic model_push(input logic [9:0] e);
    if (e[9:8] != 2'b00) m_fes = 1'b1;
    if (mq.size() < DEPTH) mq.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_div = 16'hffff;
    m_ovf = 1'b0;
    m_fes = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] s, input logic [31:0] w,
                       input logic [31:0] ed, input logic ee);
    int n = 0;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = a; mem_wstrb = s; mem_wdata = w;
    exp_rdata = ed; exp_err = ee; exp_rd = (s == 4'h0); pending = 1'b1;
    while (!mem_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!mem_ready) begin
      total++; bad++;
      $display("FAIL bus_timeout @%h: got no ready want ready", a);
      pending = 1'b0;
    end else begin
      @(negedge clk);
    end
    #1;
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic acc(input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
    logic        e;
    logic [31:0] x;
    x = model_access(a, s, w, e);
    drive(a, s, w, x, e);
  endtask

  // Read whose expected value is hand-computed; also pins the model to it
  task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] lit);
    logic        e;
    logic [31:0] x;
    x = model_access(a, 4'h0, 32'h0, e);
    check({"model_", name}, x, lit);
    drive(a, 4'h0, 32'h0, lit, e);
  endtask

  task automatic drive_bit(input logic v, input int d);
    @(posedge clk); #1;
    pin = v;
    repeat (d - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par,
                            input int brk);
    int         d;
    logic [9:0] e;
    d = (m_div < 16'd4) ? 4 : int'(m_div);
    drive_bit(1'b0, d);
    for (int i = 0; i < 8; i++) drive_bit(b[i], d);
`ifdef SERIAL_RX_PARITY_EN
    drive_bit((^b) ^ bad_par, d);
    e = {bad_par, ~stop, b};
`else
    e = {1'b0, ~stop, b};
`endif
    drive_bit(stop, d + brk);
    @(posedge clk); #1;
    pin = 1'b1;
    repeat (d / 2 + 8) @(posedge clk);
    model_push(e);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready", {31'b0, mem_ready}, 32'h0);
    check("reset_error", {31'b0, mem_error}, 32'h0);
    check("reset_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Error accesses leave div at its reset value
    acc(A_CTRL, 4'b0011, 32'h1234);
    acc(A_DATA, 4'hf, 32'h0);
    acc(A_RSVD, 4'h0, 32'h0);
    acc(A_RSVD, 4'hf, 32'h0);
    rd_lit("ctrl_reset", A_CTRL, 32'h0000_ffff);

    acc(A_CTRL, 4'hf, 32'd16);
    send_frame(8'h55, 1'b1, 1'b0, 0);
    rd_lit("data_55", A_DATA, 32'h8000_0055);
    rd_lit("data_empty", A_DATA, 32'h0);

    // Framing error followed by a held break: no extra frames while low
    send_frame(8'h00, 1'b0, 1'b0, 48);
    rd_lit("data_fe", A_DATA, 32'h8000_0100);
    rd_lit("stat_fe", A_STAT, 32'h0000_0002);
    acc(A_STAT, 4'hf, 32'h2);
    send_frame(8'h3c, 1'b1, 1'b0, 0);
    acc(A_DATA, 4'h0, 32'h0);

    // Short low glitch must not start a frame
    @(posedge clk); #1; pin = 1'b0;
    repeat (5) @(posedge clk); #1; pin = 1'b1;
    repeat (60) @(posedge clk);
    rd_lit("stat_glitch", A_STAT, 32'h0);

    // Overflow
    for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0, 0);
    rd_lit("stat_ovf", A_STAT, 32'h0000_0801);
    acc(A_STAT, 4'hf, 32'h1);
    rd_lit("stat_ovf_clr", A_STAT, 32'h0000_0800);
    for (int i = 0; i < 8; i++) acc(A_DATA, 4'h0, 32'h0);
    rd_lit("data_drained", A_DATA, 32'h0);

    // Randomized frames, divisors (including below the minimum) and accesses
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 2) == 0) acc(A_CTRL, 4'hf, 32'($urandom_range(0, 24)));
      send_frame(8'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), 0);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        case ($urandom_range(0, 4))
          0:       acc(A_STAT, 4'h0, 32'h0);
          1:       acc(A_CTRL, 4'h0, 32'h0);
          2:       acc(A_STAT, 4'hf, 32'($urandom_range(0, 3)));
          default: acc(A_DATA, 4'h0, 32'h0);
        endcase
      end
    end
    while (mq.size() > 0) acc(A_DATA, 4'h0, 32'h0);
    acc(A_STAT, 4'h0, 32'h0);

    // Reset in the middle of a frame with entries queued
    acc(A_STAT, 4'hf, 32'h3);
    acc(A_CTRL, 4'hf, 32'd16);
    for (int i = 0; i < 3; i++) send_frame(8'(8'h70 + i), 1'b1, 1'b0, 0);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 8);
    rst = 1'b1;
    pin = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (20) @(posedge clk);
    rd_lit("stat_after_rst", A_STAT, 32'h0);
    rd_lit("ctrl_after_rst", A_CTRL, 32'h0000_ffff);
    acc(A_CTRL, 4'hf, 32'd16);
    send_frame(8'ha3, 1'b1, 1'b0, 0);
    rd_lit("data_a3", A_DATA, 32'h8000_00a3);
`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'ha3, 1'b1, 1'b1, 0);
    rd_lit("data_a3_pe", A_DATA, 32'h8000_02a3);
    rd_lit("stat_pe", A_STAT, 32'h0000_0002);
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
# serial_rx

Memory-mapped asynchronous serial receiver. It is the receive-side counterpart of the `serial` bit-transmitter: it samples one input pin at a programmable clocks-per-bit rate and decodes 8N1 frames (idle high, start low, 8 data bits LSB first, stop high). Decoded bytes go into a small FIFO that the CPU drains over the standard mem bus. It sits on the peripheral bus beside `serial` and is typically looped back to that block's pin in test builds.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `mem_valid` in 1: bus request.
- `mem_addr` in 32: byte address; bits [3:2] decoded.
- `mem_wstrb` in 4: write strobes; 0 means read.
- `mem_wdata` in 32: write data.
- `mem_rdata` out 32: read data, valid while `mem_ready`.
- `mem_ready` out 1: one-cycle response pulse.
- `mem_error` out 1: access error, valid while `mem_ready`.
- `pin` in 1: asynchronous serial line.

## Operation
- Reset values:
  - `mem_ready`, `mem_error` and `mem_rdata` are 0.
  - `div` = 16'hffff.
  - FIFO empty; sticky flags clear.
  - FSM in WAIT_IDLE.
- `pin` passes through a 2-flop synchronizer; the FSM sees only the synchronized value.
- Effective divisor: `div` is latched at frame start as `d = max(div, 4)`. Writes to `div` mid-frame take effect on the next frame.
- FSM:
  - WAIT_IDLE → IDLE when line = 1.
  - IDLE → START on line = 0. The bit counter loads `d>>1`.
  - START: when the counter expires, sample. A 1 is a glitch → IDLE. A 0 → DATA, and the counter reloads `d`.
  - DATA: sample at each expiry and shift in LSB first. After 8 bits go to PARITY (macro on) or STOP.
  - STOP: sample. A 1 pushes `{fe=0, byte}` → IDLE. A 0 pushes `{fe=1, byte}` → WAIT_IDLE.
- Push when the FIFO is full: the byte is dropped and the sticky `ovf` is set. If a push and a pop occur in the same cycle on a full FIFO, both take effect and `ovf` stays clear.
- Register map (32-bit words):
  - 0x0 CTRL: write `[15:0]` = div. Read returns `{16'b0, div}`.
  - 0x4 DATA (read only): if non-empty, returns `{1'b1, 21'b0, pe, fe, byte}` and pops the entry. If empty, returns 0 with no pop.
  - 0x8 STAT: read returns `{16'b0, count[7:0], 6'b0, fe_sticky, ovf}`. A write with bit0/bit1 = 1 clears `ovf`/`fe_sticky`. `fe_sticky` sets on any push with fe or pe set.
- Accesses that return `mem_error` = 1 with `mem_ready` pulsed and no side effects:
  - writes with `mem_wstrb` ≠ 4'b1111;
  - writes to 0x4;
  - any access to 0xC.
- `rst` asserted mid-frame aborts the frame immediately and empties the FIFO.

## Timing
- A request is accepted when `mem_valid && !mem_ready`. `mem_ready` is high exactly one cycle later, then low for at least one cycle. The master must hold its request until `mem_ready`.
- Pop occurs in the accept cycle. A push in the same cycle on a previously empty FIFO is not visible to that read.
- The start-bit sample falls 2 + (d>>1) cycles after the pin falling edge (±1). Each later sample is d cycles after the previous one.
- A pushed entry is visible to DATA/STAT reads 1 cycle after the stop sample.
- `count` saturates at DEPTH, and the pointers wrap modulo DEPTH.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - frame carries one even-parity bit after bit 7, via state PARITY;
  - a mismatch sets `pe` in the entry.
- Undefined: the PARITY state is absent, the frame is 10 bits, and `pe` reads 0.

## Structure
- Shared package `serial_pkg` holds:
  - register offsets (CTRL/DATA/STAT);
  - the FSM state encoding;
  - `SERIAL_MIN_DIV` = 4;
  - the DATA word bit positions.
- One sub-module `serial_rx_fifo`: synchronous FIFO, DEPTH × 10 bits, with push/pop/full/empty/count. Simultaneous push and pop is legal in every state.

## Test plan
- Write CTRL = 16, drive frame 0x55 at 16 clk/bit → DATA read returns 0x8000_0055. A second read returns 0x0000_0000.
- Drive a 0x00 byte with stop = 0 → DATA returns 0x8000_0100 and STAT bit1 = 1. The FSM ignores new starts until the line returns high.
- Drive a 5-cycle low glitch with div = 16 → no push, and STAT count = 0.
- Send 9 frames with no reads, DEPTH = 8 → STAT = 0x0000_0801. Write STAT = 1 → reads 0x0000_0800. The first 8 bytes read back in order.
- Write CTRL with wstrb 4'b0011, write DATA, and access 0xC → each returns `mem_error` = 1. CTRL still reads 0x0000_ffff.
- Assert `rst` mid-DATA with 3 entries queued → STAT = 0. The next clean frame 0xA3 reads back 0x8000_00A3. With `SERIAL_RX_PARITY_EN`, a wrong parity on 0xA3 reads 0x8000_02A3.
